// File: rtl/drp_arbiter.sv
// Two-master round-robin DRP arbiter between the AXI-to-DRP bridge (master 0), the eye-scan
// sequencer (master 1) and the GTX DRP port. Define DRP_ARB_TIMEOUT_EN to enable the WAIT abort.
module drp_arbiter #(
    parameter int unsigned DRP_ADDR_WIDTH = 9,
    parameter int unsigned DRP_DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          AXI_aclk,
    input  logic                          AXI_aresetn,
    input  logic [1:0]                    m_drp_en,
    input  logic [1:0]                    m_drp_we,
    input  logic [2*DRP_ADDR_WIDTH-1:0]   m_drp_addr,
    input  logic [2*DRP_DATA_WIDTH-1:0]   m_drp_di,
    output logic [2*DRP_DATA_WIDTH-1:0]   m_drp_do,
    output logic [1:0]                    m_drp_rdy,
    output logic                          drp_en,
    output logic                          drp_we,
    output logic [DRP_ADDR_WIDTH-1:0]     drp_addr,
    output logic [DRP_DATA_WIDTH-1:0]     drp_di,
    input  logic [DRP_DATA_WIDTH-1:0]     drp_do,
    input  logic                          drp_rdy,
    output logic                          busy,
    output logic [1:0]                    overrun,
    output logic                          drp_timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    logic [1:0]                           pend_q, pend_d;
    logic [1:0]                           grant_clr;
    logic [1:0]                           capture;
    logic                                 gnt_q, gnt_d, gnt_sel;
    logic                                 last_q, last_d;

    logic [1:0]                           lat_we_q;
    logic [1:0][DRP_ADDR_WIDTH-1:0]       lat_addr_q;
    logic [1:0][DRP_DATA_WIDTH-1:0]       lat_di_q;
    logic [1:0][DRP_ADDR_WIDTH-1:0]       m_addr;
    logic [1:0][DRP_DATA_WIDTH-1:0]       m_di;

    logic                                 drp_en_q, drp_en_d;
    logic                                 drp_we_q, drp_we_d;
    logic [DRP_ADDR_WIDTH-1:0]            drp_addr_q, drp_addr_d;
    logic [DRP_DATA_WIDTH-1:0]            drp_di_q, drp_di_d;
    logic [1:0][DRP_DATA_WIDTH-1:0]       m_do_q, m_do_d;
    logic [1:0]                           m_rdy_q, m_rdy_d;
    logic [1:0]                           overrun_q;

    assign m_addr  = m_drp_addr;
    assign m_di    = m_drp_di;

    // A strobe is only accepted into an empty slot; otherwise it is an overrun.
    assign capture = m_drp_en & ~pend_q;
    assign pend_d  = (pend_q & ~grant_clr) | capture;

    // Contention goes to whoever was not served last; reset value of last_q favours master 0.
    assign gnt_sel = (pend_q == 2'b11) ? ~last_q : pend_q[1];

`ifdef DRP_ARB_TIMEOUT_EN
    localparam logic [15:0] TermCount = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        grant_clr  = '0;
        drp_en_d   = 1'b0;
        drp_we_d   = 1'b0;
        drp_addr_d = drp_addr_q;
        drp_di_d   = drp_di_q;
        m_do_d     = m_do_q;
        m_rdy_d    = '0;
`ifdef DRP_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    gnt_d              = gnt_sel;
                    last_d             = gnt_sel;
                    grant_clr[gnt_sel] = 1'b1;
                    drp_en_d           = 1'b1;
                    drp_we_d           = lat_we_q[gnt_sel];
                    drp_addr_d         = lat_addr_q[gnt_sel];
                    drp_di_d           = lat_di_q[gnt_sel];
                    state_d            = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef DRP_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (drp_rdy) begin
                    m_rdy_d[gnt_q] = 1'b1;
                    m_do_d[gnt_q]  = drp_do;
                    state_d        = StIdle;
                end
`ifdef DRP_ARB_TIMEOUT_EN
                else if (cnt_q == TermCount) begin
                    m_rdy_d[gnt_q] = 1'b1;
                    m_do_d[gnt_q]  = '1;
                    timeout_d      = 1'b1;
                    state_d        = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            state_q    <= StIdle;
            pend_q     <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            drp_en_q   <= 1'b0;
            drp_we_q   <= 1'b0;
            drp_addr_q <= '0;
            drp_di_q   <= '0;
            m_do_q     <= '0;
            m_rdy_q    <= '0;
            overrun_q  <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            drp_en_q   <= drp_en_d;
            drp_we_q   <= drp_we_d;
            drp_addr_q <= drp_addr_d;
            drp_di_q   <= drp_di_d;
            m_do_q     <= m_do_d;
            m_rdy_q    <= m_rdy_d;
            overrun_q  <= overrun_q | (m_drp_en & pend_q);
        end
    end

    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            lat_we_q   <= '0;
            lat_addr_q <= '0;
            lat_di_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    lat_we_q[i]   <= m_drp_we[i];
                    lat_addr_q[i] <= m_addr[i];
                    lat_di_q[i]   <= m_di[i];
                end
            end
        end
    end

`ifdef DRP_ARB_TIMEOUT_EN
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign drp_timeout = timeout_q;
`else
    assign drp_timeout = 1'b0;
`endif

    assign drp_en    = drp_en_q;
    assign drp_we    = drp_we_q;
    assign drp_addr  = drp_addr_q;
    assign drp_di    = drp_di_q;
    assign m_drp_do  = m_do_q;
    assign m_drp_rdy = m_rdy_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle) | (|pend_q);

endmodule

// File: tb/tb_drp_arbiter.sv
// Scoreboard bench for drp_arbiter: expected issues/completions are queued by the stimulus
// and popped by independent monitors. Timeout checks run only with DRP_ARB_TIMEOUT_EN defined.
module tb_drp_arbiter;

    logic        AXI_aclk = 1'b0;
    logic        AXI_aresetn = 1'b0;
    logic [1:0]  m_drp_en = '0;
    logic [1:0]  m_drp_we = '0;
    logic [17:0] m_drp_addr = '0;
    logic [31:0] m_drp_di = '0;
    logic [31:0] m_drp_do;
    logic [1:0]  m_drp_rdy;
    logic        drp_en;
    logic        drp_we;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_rdy = 1'b0;
    logic        busy;
    logic [1:0]  overrun;
    logic        drp_timeout;

    always #5 AXI_aclk = ~AXI_aclk;

    drp_arbiter #(
        .DRP_ADDR_WIDTH(9),
        .DRP_DATA_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .AXI_aclk   (AXI_aclk),
        .AXI_aresetn(AXI_aresetn),
        .m_drp_en   (m_drp_en),
        .m_drp_we   (m_drp_we),
        .m_drp_addr (m_drp_addr),
        .m_drp_di   (m_drp_di),
        .m_drp_do   (m_drp_do),
        .m_drp_rdy  (m_drp_rdy),
        .drp_en     (drp_en),
        .drp_we     (drp_we),
        .drp_addr   (drp_addr),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_rdy    (drp_rdy),
        .busy       (busy),
        .overrun    (overrun),
        .drp_timeout(drp_timeout)
    );

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [15:0] di;
    } iss_t;

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] data;
    } cmp_t;

    iss_t        iss_q[$];
    cmp_t        cmp_q[$];
    iss_t        iss_exp;
    cmp_t        cmp_exp;
    int          checks = 0;
    int          errors = 0;
    int          en_pulses = 0;
    int          to_pulses = 0;
    int          t_wait;
    int          k_wait;
    logic        prev_en = 1'b0;
    logic        rsp_enable = 1'b1;
    logic [31:0] exp_do = '0;
    logic [15:0] mem [512];
    logic        mdl_we;
    logic [8:0]  mdl_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_issue(input logic we, input logic [8:0] addr, input logic [15:0] di);
        iss_t e;
        e.we = we;
        e.addr = addr;
        e.di = di;
        iss_q.push_back(e);
    endtask

    task automatic exp_cmp(input int m, input logic [15:0] d);
        cmp_t c;
        exp_do[m*16 +: 16] = d;
        c.mask = (m == 0) ? 2'b01 : 2'b10;
        c.data = exp_do;
        cmp_q.push_back(c);
    endtask

    task automatic strobe(input logic [1:0] en, input logic [1:0] we,
                          input logic [8:0] a0, input logic [15:0] d0,
                          input logic [8:0] a1, input logic [15:0] d1);
        @(negedge AXI_aclk);
        m_drp_en   = en;
        m_drp_we   = we;
        m_drp_addr = {a1, a0};
        m_drp_di   = {d1, d0};
        @(negedge AXI_aclk);
        m_drp_en   = '0;
        m_drp_we   = '0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy || cmp_q.size() != 0 || iss_q.size() != 0) && n < 300) begin
            @(negedge AXI_aclk);
            n++;
        end
        check({name, " completes"}, 64'(n < 300), 64'd1);
    endtask

    // Transceiver model: answers two cycles after seeing drp_en, unless disabled.
    initial begin
        forever begin
            @(negedge AXI_aclk);
            if (drp_en && rsp_enable) begin
                mdl_we   = drp_we;
                mdl_addr = drp_addr;
                if (mdl_we) mem[mdl_addr] = drp_di;
                repeat (2) @(negedge AXI_aclk);
                drp_do  = mdl_we ? 16'h0000 : mem[mdl_addr];
                drp_rdy = 1'b1;
                @(negedge AXI_aclk);
                drp_rdy = 1'b0;
            end
        end
    end

    // Issue monitor
    initial begin
        forever begin
            @(negedge AXI_aclk);
            if (drp_en) begin
                en_pulses++;
                check("drp_en single cycle", 64'(prev_en), 64'd0);
                if (iss_q.size() == 0) begin
                    check("unexpected drp_en", 64'd1, 64'd0);
                end else begin
                    iss_exp = iss_q.pop_front();
                    check("issue we/addr/di", 64'({drp_we, drp_addr, drp_di}), 64'(iss_exp));
                end
            end else if (prev_en) begin
                check("drp_we falls with drp_en", 64'(drp_we), 64'd0);
            end
            prev_en = drp_en;
            if (drp_timeout) to_pulses++;
        end
    end

    // Completion monitor
    initial begin
        forever begin
            @(negedge AXI_aclk);
            if (m_drp_rdy != 2'b00) begin
                if (cmp_q.size() == 0) begin
                    check("unexpected m_drp_rdy", 64'(m_drp_rdy), 64'd0);
                end else begin
                    cmp_exp = cmp_q.pop_front();
                    check("m_drp_rdy mask", 64'(m_drp_rdy), 64'(cmp_exp.mask));
                    check("m_drp_do", 64'(m_drp_do), 64'(cmp_exp.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h04F] = 16'hA5C3;
        mem[9'h030] = 16'hBEEF;

        repeat (3) @(negedge AXI_aclk);
        check("reset m-side outputs", {m_drp_do, m_drp_rdy, overrun, drp_timeout, busy}, 64'd0);
        check("reset drp outputs", 64'({drp_en, drp_we, drp_addr, drp_di}), 64'd0);
        AXI_aresetn = 1'b1;

        // Simultaneous writes right after reset: master 0 first.
        exp_issue(1'b1, 9'h010, 16'h1234);
        exp_issue(1'b1, 9'h020, 16'h5678);
        exp_cmp(0, 16'h0000);
        exp_cmp(1, 16'h0000);
        strobe(2'b11, 2'b11, 9'h010, 16'h1234, 9'h020, 16'h5678);
        wait_done("dual write");

        // Master 0 read, slice 1 must hold.
        exp_issue(1'b0, 9'h04F, 16'h0000);
        exp_cmp(0, 16'hA5C3);
        strobe(2'b01, 2'b00, 9'h04F, 16'h0000, 9'h000, 16'h0000);
        wait_done("m0 read");

        // Grant order m1, m0, m1, m1.
        exp_issue(1'b0, 9'h020, 16'h0000);
        exp_cmp(1, 16'h5678);
        strobe(2'b10, 2'b00, 9'h000, 16'h0000, 9'h020, 16'h0000);
        repeat (2) @(negedge AXI_aclk);
        exp_issue(1'b0, 9'h010, 16'h0000);
        exp_issue(1'b0, 9'h04F, 16'h0000);
        exp_cmp(0, 16'h1234);
        exp_cmp(1, 16'hA5C3);
        strobe(2'b11, 2'b00, 9'h010, 16'h0000, 9'h04F, 16'h0000);
        wait_done("rr pair");
        exp_issue(1'b0, 9'h030, 16'h0000);
        exp_cmp(1, 16'hBEEF);
        strobe(2'b10, 2'b00, 9'h000, 16'h0000, 9'h030, 16'h0000);
        wait_done("m1 third");

        // Overrun: second strobe while pending is dropped.
        exp_issue(1'b0, 9'h04F, 16'h0000);
        exp_cmp(0, 16'hA5C3);
        @(negedge AXI_aclk);
        m_drp_en = 2'b01; m_drp_we = 2'b00; m_drp_addr = {9'h000, 9'h04F}; m_drp_di = '0;
        @(negedge AXI_aclk);
        m_drp_we = 2'b01; m_drp_addr = {9'h000, 9'h123}; m_drp_di = {16'h0000, 16'hFFFF};
        @(negedge AXI_aclk);
        m_drp_en = '0; m_drp_we = '0;
        wait_done("overrun");
        check("overrun flag", 64'(overrun), 64'd1);
        check("drp_en pulse count", 64'(en_pulses), 64'd8);

        // Back-to-back: new strobe in the m_drp_rdy cycle.
        exp_issue(1'b0, 9'h010, 16'h0000);
        exp_issue(1'b0, 9'h030, 16'h0000);
        exp_cmp(0, 16'h1234);
        exp_cmp(0, 16'hBEEF);
        strobe(2'b01, 2'b00, 9'h010, 16'h0000, 9'h000, 16'h0000);
        t_wait = 0;
        while (!m_drp_rdy[0] && t_wait < 50) begin
            @(negedge AXI_aclk);
            t_wait++;
        end
        check("b2b first rdy seen", 64'(t_wait < 50), 64'd1);
        m_drp_en = 2'b01; m_drp_addr = {9'h000, 9'h030}; m_drp_di = '0;
        @(negedge AXI_aclk);
        m_drp_en = '0;
        wait_done("back-to-back");
        check("overrun sticky", 64'(overrun), 64'd1);

        // Spurious drp_rdy in IDLE.
        @(negedge AXI_aclk);
        drp_do = 16'hDEAD;
        drp_rdy = 1'b1;
        @(negedge AXI_aclk);
        drp_rdy = 1'b0;
        check("spurious rdy ignored", 64'(m_drp_rdy), 64'd0);
        check("spurious busy", 64'(busy), 64'd0);

        // Reset during WAIT.
        rsp_enable = 1'b0;
        exp_issue(1'b1, 9'h040, 16'h9999);
        strobe(2'b10, 2'b10, 9'h000, 16'h0000, 9'h040, 16'h9999);
        repeat (4) @(negedge AXI_aclk);
        check("busy in WAIT", 64'(busy), 64'd1);
        AXI_aresetn = 1'b0;
        #1;
        check("mid reset m-side", {m_drp_do, m_drp_rdy, overrun, drp_timeout, busy}, 64'd0);
        check("mid reset drp side", 64'({drp_en, drp_we, drp_addr, drp_di}), 64'd0);
        @(negedge AXI_aclk);
        AXI_aresetn = 1'b1;
        exp_do = '0;
        rsp_enable = 1'b1;
        repeat (3) @(negedge AXI_aclk);
        check("busy after reset", 64'(busy), 64'd0);
        exp_issue(1'b0, 9'h04F, 16'h0000);
        exp_cmp(0, 16'hA5C3);
        strobe(2'b01, 2'b00, 9'h04F, 16'h0000, 9'h000, 16'h0000);
        wait_done("post-reset read");

`ifdef DRP_ARB_TIMEOUT_EN
        rsp_enable = 1'b0;
        exp_issue(1'b0, 9'h010, 16'h0000);
        exp_cmp(0, 16'hFFFF);
        strobe(2'b01, 2'b00, 9'h010, 16'h0000, 9'h000, 16'h0000);
        t_wait = 0;
        while (!drp_en && t_wait < 20) begin
            @(negedge AXI_aclk);
            t_wait++;
        end
        k_wait = 0;
        while (!m_drp_rdy[0] && k_wait < 50) begin
            @(negedge AXI_aclk);
            k_wait++;
        end
        check("timeout latency", 64'(k_wait), 64'd9);
        check("drp_timeout pulse", 64'(drp_timeout), 64'd1);
        drp_do = 16'h1111;
        drp_rdy = 1'b1;
        @(negedge AXI_aclk);
        drp_rdy = 1'b0;
        @(negedge AXI_aclk);
        check("late rdy ignored", 64'(m_drp_rdy), 64'd0);
        rsp_enable = 1'b1;
        wait_done("timeout");
        check("timeout pulse count", 64'(to_pulses), 64'd1);
`else
        check("no timeout pulses", 64'(to_pulses), 64'd0);
`endif

        repeat (3) @(negedge AXI_aclk);
        check("issue queue drained", 64'(iss_q.size()), 64'd0);
        check("completion queue drained", 64'(cmp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drp_arbiter.md
Name: drp_arbiter

Overview:
Two-master to one-slave DRP arbiter that sits directly downstream of the AXI-to-DRP bridge and in front of the GTX transceiver DRP port. Master 0 is the AXI bridge. Master 1 is the local eye-scan sequencer. Each single-cycle DRP request is captured, granted round-robin, issued to the transceiver, and the completion is routed back only to the requesting master.

Parameters:
DRP_ADDR_WIDTH, 9, DRP address width.
DRP_DATA_WIDTH, 16, DRP data width.
TIMEOUT_CYCLES, 64, cycles to wait for drp_rdy before abort; used only with the optional feature; legal range 2..65535.

Ports:
AXI_aclk  in  1  single clock for the whole block.
AXI_aresetn  in  1  reset, asynchronous assert, active-low.
m_drp_en  in  2  per-master request strobe, bit i = master i.
m_drp_we  in  2  per-master write enable, qualified by m_drp_en.
m_drp_addr  in  2*DRP_ADDR_WIDTH  master i address in slice i.
m_drp_di  in  2*DRP_DATA_WIDTH  master i write data in slice i.
m_drp_do  out  2*DRP_DATA_WIDTH  read data to master i in slice i.
m_drp_rdy  out  2  per-master completion pulse.
drp_en  out  1  transceiver DRP enable.
drp_we  out  1  transceiver DRP write enable.
drp_addr  out  DRP_ADDR_WIDTH  transceiver DRP address.
drp_di  out  DRP_DATA_WIDTH  transceiver write data.
drp_do  in  DRP_DATA_WIDTH  transceiver read data.
drp_rdy  in  1  transceiver completion.
busy  out  1  high while any request is pending or in flight.
overrun  out  2  sticky per-master protocol-error flag.
drp_timeout  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: all outputs are 0. Pending latches are cleared, state is IDLE, and the round-robin pointer favours master 0.
- Capture: when m_drp_en[i]=1 at a clock edge, pend[i] is set and we/addr/di for master i are latched.
- Overrun: if m_drp_en[i]=1 while pend[i] is already set, the request is dropped, the latched request is untouched, and overrun[i] is set. overrun clears only on reset.
- State IDLE:
  - If any pend bit is set, grant per the round-robin rule.
  - Register drp_en=1 with drp_we/addr/di from the granted latch, clear that pend bit, and go to ISSUE.
  - A request captured on edge N is issued on edge N+1 at the earliest.
- Round-robin rule: if only one master is pending, grant it. If both are pending, grant the master not granted last; after reset, master 0 wins.
- State ISSUE: drp_en and drp_we fall to 0 on the next edge (exactly one cycle high); go to WAIT. drp_addr and drp_di hold their values until the next grant.
- State WAIT: on the edge where drp_rdy=1:
  - m_drp_rdy[g] pulses for one cycle.
  - Slice g of m_drp_do is loaded with drp_do. The non-granted slice holds its value.
  - Return to IDLE.
- Total latency: m_drp_rdy is registered one cycle after drp_rdy.
- Spurious drp_rdy: drp_rdy seen in IDLE or ISSUE is ignored.
- Back-to-back requests: a master may assert m_drp_en in the same cycle its m_drp_rdy is high; the request is captured normally.
- Busy: busy = (state != IDLE) | (|pend).
- Reset mid-operation: the in-flight transaction and pending requests are discarded and no m_drp_rdy is generated. drp_en drops asynchronously.

Optional Feature:
Macro DRP_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES with no drp_rdy, m_drp_rdy[g] pulses, slice g of m_drp_do is all ones, drp_timeout pulses for one cycle, and the state returns to IDLE.
  - A late drp_rdy is treated as spurious.
  - If drp_rdy arrives on the terminal-count cycle, drp_rdy wins and there is no timeout.
- Undefined: WAIT holds indefinitely, there is no counter logic, and drp_timeout is tied to 0.

Test Plan:
- Master 0 read, addr 0x04F; transceiver model returns 0xA5C3 three cycles after drp_en -> drp_en is high one cycle with addr 0x04F and we=0; m_drp_rdy = 2'b01; slice 0 = 0xA5C3; slice 1 unchanged.
- Both masters strobe in the same cycle after reset: m0 write 0x010 <= 0x1234, m1 write 0x020 <= 0x5678 -> m0 is issued first, m1 second; two separate drp_en pulses; m_drp_rdy 01 then 10.
- Master 1 issues three consecutive requests while master 0 issues one -> grant order alternates m1, m0, m1, m1.
- Master 0 strobes twice before its first completes -> second request is dropped; overrun = 2'b01; only one drp_en for master 0.
- With DRP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, transceiver never returns rdy -> after 8 WAIT cycles m_drp_rdy[0]=1, slice 0 = 0xFFFF, drp_timeout pulses; a later drp_rdy is ignored.
- Assert AXI_aresetn=0 during WAIT, then release -> all outputs are 0, no m_drp_rdy, busy=0; the next request completes normally.
